// File: rtl/array_max_engine_if.sv
// Request/result and memory-port signals of the array maximum scan engine.
// The engine connects through the slave modport; the processor/memory side uses master.
interface array_max_engine_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] result_addr;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] max_value;
  logic [ADDR_W-1:0] max_addr;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output start, base, count, result_addr, mem_read_data,
    input  busy, done, max_value, max_addr,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  start, base, count, result_addr, mem_read_data,
    output busy, done, max_value, max_addr,
    output mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/array_max_engine.sv
// Scans count bytes from base, finds the first-occurring unsigned maximum,
// writes value and address to result_addr/result_addr+1, then pulses done.
module array_max_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  array_max_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SCAN, WR_VAL, WR_IDX, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] res_addr;
  logic [DATA_W-1:0] run_max;
  logic [ADDR_W-1:0] run_addr;
  logic              first;

  logic              take;
  logic [DATA_W-1:0] scan_max;
  logic [ADDR_W-1:0] scan_addr;

  // Running max including the element currently on the read port, so the
  // WR_VAL data can be registered on the same edge that ends the scan.
  always_comb begin
    take      = first || (bus.mem_read_data > run_max);
    scan_max  = take ? bus.mem_read_data : run_max;
    scan_addr = take ? ptr : run_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      ptr                <= '0;
      remaining          <= '0;
      res_addr           <= '0;
      run_max            <= '0;
      run_addr           <= '0;
      first              <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.max_value      <= '0;
      bus.max_addr       <= '0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.mem_read       <= 1'b0;
      bus.mem_write      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ptr       <= bus.base;
            remaining <= bus.count;
            res_addr  <= bus.result_addr;
            first     <= 1'b1;
            if (bus.count != '0) begin
              state           <= SCAN;
              bus.busy        <= 1'b1;
              bus.mem_read    <= 1'b1;
              bus.mem_address <= bus.base;
            end else begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.max_value <= '0;
              bus.max_addr  <= bus.base;
            end
          end
        end
        SCAN: begin
          run_max   <= scan_max;
          run_addr  <= scan_addr;
          first     <= 1'b0;
          remaining <= remaining - ADDR_W'(1);
          if (remaining == ADDR_W'(1)) begin
            state              <= WR_VAL;
            bus.mem_read       <= 1'b0;
            bus.mem_write      <= 1'b1;
            bus.mem_address    <= res_addr;
            bus.mem_write_data <= scan_max;
          end else begin
            ptr             <= ptr + 1'b1;
            bus.mem_address <= ptr + 1'b1;
          end
        end
        WR_VAL: begin
          state              <= WR_IDX;
          bus.mem_address    <= res_addr + 1'b1;
          bus.mem_write_data <= DATA_W'(run_addr);
        end
        WR_IDX: begin
          state              <= DONE;
          bus.busy           <= 1'b0;
          bus.mem_write      <= 1'b0;
          bus.mem_address    <= '0;
          bus.mem_write_data <= '0;
          bus.done           <= 1'b1;
          bus.max_value      <= run_max;
          bus.max_addr       <= run_addr;
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_max_engine.sv
// Self-checking bench for array_max_engine with a behavioural memory and max model.
module tb_array_max_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  array_max_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  array_max_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem  [256];
  logic [7:0] snap [256];
  logic [7:0] rd_q [$];
  int wr_cnt, done_cnt, both_hi;
  int n_checks = 0;
  int n_pass   = 0;

  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address] : 8'h00;

  always @(posedge clk) begin
    if (bus.mem_read && bus.mem_write) both_hi++;
    if (bus.mem_read) rd_q.push_back(bus.mem_address);
    if (bus.mem_write) begin
      mem[bus.mem_address] = bus.mem_write_data;
      wr_cnt++;
    end
    if (bus.done) done_cnt++;
  end

  // Reference: first occurrence of the largest byte in the (wrapping) range of snap.
  function automatic void model(input logic [7:0] b, input logic [7:0] c,
                                output logic [7:0] mv, output logic [7:0] ma);
    mv = 8'h00;
    ma = b;
    for (int i = 0; i < int'(c); i++) begin
      int a = (int'(b) + i) % 256;
      if (i == 0 || snap[a] > mv) begin
        mv = snap[a];
        ma = 8'(a);
      end
    end
  endfunction

  task automatic clear_mon();
    rd_q.delete();
    wr_cnt = 0; done_cnt = 0; both_hi = 0;
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 127);
    mem[112] = 8'hF5;
    mem[117] = 8'hF5;
    mem[120] = 8'hFF;
  endtask

  // Drives one request and measures latency to done (-1 if never seen).
  task automatic run_op(input logic [7:0] b, input logic [7:0] c, input logic [7:0] r,
                        output int lat, output int busy_bad);
    logic exp_busy;
    snap = mem;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.base = b; bus.count = c; bus.result_addr = r;
    @(negedge clk);
    bus.start = 1'b0;
    lat = -1; busy_bad = 0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      exp_busy = (c != 8'd0) && (cyc <= int'(c) + 2);
      if (bus.busy !== exp_busy) busy_bad++;
      if (bus.done === 1'b1) begin lat = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.base = 8'd3; bus.count = 8'd5; bus.result_addr = 8'd9;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus.busy, bus.done, bus.max_value, bus.max_addr} !== 18'd0)
      $display("FAIL reset_status: got %0h want 0", {bus.busy, bus.done, bus.max_value, bus.max_addr}); else n_pass++;
    n_checks++; if ({bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write} !== 18'd0)
      $display("FAIL reset_mem: got %0h want 0", {bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write}); else n_pass++;
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.mem_read} !== 2'b00)
      $display("FAIL reset_wins_start: busy/mem_read got %b want 00", {bus.busy, bus.mem_read}); else n_pass++;
  endtask

  task automatic test_image();
    int lat, bb;
    logic [7:0] mv, ma;
    load_image();
    run_op(8'd106, 8'd14, 8'd130, lat, bb);
    model(8'd106, 8'd14, mv, ma);
    n_checks++; if (lat !== 17) $display("FAIL img14_latency: got %0d want 17", lat); else n_pass++;
    n_checks++; if (bb !== 0) $display("FAIL img14_busy: %0d bad cycles want 0", bb); else n_pass++;
    n_checks++; if (bus.max_value !== 8'hF5 || mv !== 8'hF5) $display("FAIL img14_max_value: got %0h model %0h want f5", bus.max_value, mv); else n_pass++;
    n_checks++; if (bus.max_addr !== 8'd112 || ma !== 8'd112) $display("FAIL img14_max_addr: got %0d model %0d want 112", bus.max_addr, ma); else n_pass++;
    @(negedge clk);
    n_checks++; if (mem[130] !== 8'hF5 || mem[131] !== 8'h70) $display("FAIL img14_mem: got %0h %0h want f5 70", mem[130], mem[131]); else n_pass++;
    load_image();
    run_op(8'd106, 8'd15, 8'd130, lat, bb);
    n_checks++; if (lat !== 18) $display("FAIL img15_latency: got %0d want 18", lat); else n_pass++;
    n_checks++; if (bus.max_value !== 8'hFF || bus.max_addr !== 8'd120) $display("FAIL img15_result: got %0h@%0d want ff@120", bus.max_value, bus.max_addr); else n_pass++;
    n_checks++; if (both_hi !== 0) $display("FAIL img15_rd_wr_overlap: got %0d want 0", both_hi); else n_pass++;
  endtask

  task automatic test_tie_wrap();
    int lat, bb;
    mem[255] = 8'h40; mem[0] = 8'h40; mem[1] = 8'h10;
    run_op(8'd255, 8'd3, 8'd200, lat, bb);
    @(negedge clk);
    n_checks++; if (rd_q.size() !== 3 || rd_q[0] !== 8'd255 || rd_q[1] !== 8'd0 || rd_q[2] !== 8'd1)
      $display("FAIL wrap_reads: got %0d reads want 255,0,1", rd_q.size()); else n_pass++;
    n_checks++; if (bus.max_value !== 8'h40 || bus.max_addr !== 8'd255) $display("FAIL tie_result: got %0h@%0d want 40@255", bus.max_value, bus.max_addr); else n_pass++;
    n_checks++; if (mem[200] !== 8'h40 || mem[201] !== 8'hFF) $display("FAIL tie_mem: got %0h %0h want 40 ff", mem[200], mem[201]); else n_pass++;
  endtask

  task automatic test_count_zero();
    int lat, bb;
    run_op(8'd50, 8'd0, 8'd60, lat, bb);
    n_checks++; if (lat !== 1) $display("FAIL zero_latency: got %0d want 1", lat); else n_pass++;
    n_checks++; if (bus.max_value !== 8'h00 || bus.max_addr !== 8'd50) $display("FAIL zero_result: got %0h@%0d want 0@50", bus.max_value, bus.max_addr); else n_pass++;
    n_checks++; if ({bus.busy, bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write} !== 19'd0)
      $display("FAIL zero_done_outputs: got %0h want 0", {bus.busy, bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write}); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_q.size() !== 0 || wr_cnt !== 0) $display("FAIL zero_mem_access: reads %0d writes %0d want 0 0", rd_q.size(), wr_cnt); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    logic [7:0] mv, ma;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    snap = mem;
    model(8'd30, 8'd10, mv, ma);
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.base = 8'd30; bus.count = 8'd10; bus.result_addr = 8'd220;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == 3) begin
        bus.start = 1'b1; bus.base = 8'd0; bus.count = 8'd5; bus.result_addr = 8'd100;
      end else bus.start = 1'b0;
      if (bus.done === 1'b1) begin lat = cyc; break; end
      @(negedge clk);
    end
    bus.start = 1'b0;
    n_checks++; if (lat !== 13) $display("FAIL ignore_latency: got %0d want 13", lat); else n_pass++;
    n_checks++; if (bus.max_value !== mv || bus.max_addr !== ma) $display("FAIL ignore_result: got %0h@%0d want %0h@%0d", bus.max_value, bus.max_addr, mv, ma); else n_pass++;
    repeat (20) @(negedge clk);
    n_checks++; if (done_cnt !== 1 || wr_cnt !== 2) $display("FAIL ignore_counts: done %0d writes %0d want 1 2", done_cnt, wr_cnt); else n_pass++;
    n_checks++; if (mem[100] !== snap[100] || mem[220] !== mv) $display("FAIL ignore_mem: got %0h %0h want %0h %0h", mem[100], mem[220], snap[100], mv); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, bb;
    logic [7:0] mv, ma;
    snap = mem;
    clear_mon();
    @(negedge clk);
    bus.start = 1'b1; bus.base = 8'd10; bus.count = 8'd20; bus.result_addr = 8'd210;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({bus.busy, bus.done, bus.max_value, bus.max_addr, bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write} !== 36'd0)
      $display("FAIL midrst_outputs: got %0h want 0", {bus.busy, bus.done, bus.max_value, bus.max_addr, bus.mem_address, bus.mem_write_data, bus.mem_read, bus.mem_write}); else n_pass++;
    rst = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (done_cnt !== 0 || wr_cnt !== 0 || rd_q.size() !== 5) $display("FAIL midrst_activity: done %0d writes %0d reads %0d want 0 0 5", done_cnt, wr_cnt, rd_q.size()); else n_pass++;
    n_checks++; if (mem[210] !== snap[210] || mem[211] !== snap[211]) $display("FAIL midrst_mem: got %0h %0h want %0h %0h", mem[210], mem[211], snap[210], snap[211]); else n_pass++;
    run_op(8'd10, 8'd20, 8'd210, lat, bb);
    model(8'd10, 8'd20, mv, ma);
    n_checks++; if (lat !== 23 || bus.max_value !== mv || bus.max_addr !== ma)
      $display("FAIL midrst_rerun: lat %0d %0h@%0d want 23 %0h@%0d", lat, bus.max_value, bus.max_addr, mv, ma); else n_pass++;
  endtask

  task automatic test_random();
    int lat, bb;
    logic [7:0] b, c, r, mv, ma;
    for (int unsigned it = 0; it < 10; it++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, (it % 2 == 0) ? 15 : 255));
      b = 8'($urandom);
      c = (it == 1) ? 8'd255 : 8'($urandom_range(1, 40));
      r = (it == 0) ? 8'd255 : 8'($urandom);
      snap = mem;
      model(b, c, mv, ma);
      run_op(b, c, r, lat, bb);
      @(negedge clk);
      n_checks++; if (lat !== int'(c) + 3 || bb !== 0) $display("FAIL rand%0d_timing: lat %0d busy_bad %0d want %0d 0", it, lat, bb, int'(c) + 3); else n_pass++;
      n_checks++; if (bus.max_value !== mv || bus.max_addr !== ma)
        $display("FAIL rand%0d_result: got %0h@%0d want %0h@%0d", it, bus.max_value, bus.max_addr, mv, ma); else n_pass++;
      n_checks++; if (mem[r] !== mv || mem[8'(r + 8'd1)] !== ma || wr_cnt !== 2 || rd_q.size() !== int'(c) || both_hi !== 0)
        $display("FAIL rand%0d_mem: got %0h %0h w%0d r%0d o%0d want %0h %0h w2 r%0d o0", it, mem[r], mem[8'(r + 8'd1)], wr_cnt, rd_q.size(), both_hi, mv, ma, c); else n_pass++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.base = '0; bus.count = '0; bus.result_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    clear_mon();
    test_reset();
    test_image();
    test_tie_wrap();
    test_count_zero();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
